// File: rtl/traffic_sched.sv
`default_nettype none
// ============================================================================
// Module      : traffic_sched
// Description : Two-road traffic light scheduler with pedestrian all-red walk
//               phase and emergency all-red override. Dwell times are counted
//               in ticks of an external timebase enable.
//   clk       in   1  single clock, rising edge
//   reset     in   1  synchronous, active-low reset
//   tick      in   1  timebase enable, one-cycle pulse
//   a, b      in   1  vehicle present on road A / road B
//   ped_req   in   1  pedestrian button, sampled every clk
//   emg       in   1  emergency all-red request, level
//   LA, LB    out  2  road lights (green=00, yellow=01, red=10)
//   walk      out  1  pedestrian walk lamp
//   ped_pend  out  1  pedestrian request latched, not yet served
//   phase     out  3  current state code
// Revision    : 1.0 - initial release
// ============================================================================
module traffic_sched #(
    parameter int GMIN = 5,
    parameter int GMAX = 20,
    parameter int YEL  = 3,
    parameter int WALK = 6,
    parameter int CW   = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       a,
    input  logic       b,
    input  logic       ped_req,
    input  logic       emg,
    output logic [1:0] LA,
    output logic [1:0] LB,
    output logic       walk,
    output logic       ped_pend,
    output logic [2:0] phase
);

    typedef enum logic [2:0] {
        AG = 3'd0,
        AY = 3'd1,
        BG = 3'd2,
        BY = 3'd3,
        PW = 3'd4,
        ER = 3'd5
    } state_t;

    localparam logic [1:0] GRN = 2'b00;
    localparam logic [1:0] YLW = 2'b01;
    localparam logic [1:0] RED = 2'b10;

    localparam logic LAST_A = 1'b0;
    localparam logic LAST_B = 1'b1;

    // Thresholds compared against n = cnt+1, which needs one extra bit.
    localparam logic [CW:0] GMIN_N = (CW+1)'(GMIN);
    localparam logic [CW:0] GMAX_N = (CW+1)'(GMAX);
    localparam logic [CW:0] YEL_N  = (CW+1)'(YEL);
    localparam logic [CW:0] WALK_N = (CW+1)'(WALK);
    localparam logic [CW-1:0] GMAX_C = CW'(GMAX);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          last_q, last_d;
    logic          ped_q, ped_d;
    logic [1:0]    la_q, la_d;
    logic [1:0]    lb_q, lb_d;
    logic          walk_q, walk_d;

    logic [CW:0]   n;

    assign n = {1'b0, cnt_q} + {{CW{1'b0}}, 1'b1};

    always_comb begin
        state_d = state_q;
        last_d  = last_q;

        if (emg) begin
            state_d = ER;
        end else begin
            case (state_q)
                AG: if (tick && (b || ped_q) &&
                        (((n >= GMIN_N) && !a) || (n >= GMAX_N)))
                        state_d = AY;
                AY: if (tick && (n >= YEL_N)) begin
                        state_d = ped_q ? PW : BG;
                        last_d  = LAST_A;
                    end
                BG: if (tick && (a || ped_q) &&
                        (((n >= GMIN_N) && !b) || (n >= GMAX_N)))
                        state_d = BY;
                BY: if (tick && (n >= YEL_N)) begin
                        state_d = ped_q ? PW : AG;
                        last_d  = LAST_B;
                    end
                PW: if (tick && (n >= WALK_N))
                        state_d = (last_q == LAST_A) ? BG : AG;
                ER: state_d = AG;
                default: state_d = AG;
            endcase
        end

        // Dwell counter restarts on any state change, else saturating count.
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (tick && (cnt_q != GMAX_C)) begin
            cnt_d = cnt_q + 1'b1;
        end else begin
            cnt_d = cnt_q;
        end

        // Entering PW serves the request and beats a coincident press;
        // presses during PW are ignored.
        if ((state_d == PW) && (state_q != PW)) begin
            ped_d = 1'b0;
        end else if (ped_req && (state_q != PW)) begin
            ped_d = 1'b1;
        end else begin
            ped_d = ped_q;
        end

        // Lamps are decoded from the next state so they update on the same
        // edge as the state register.
        la_d   = RED;
        lb_d   = RED;
        walk_d = 1'b0;
        case (state_d)
            AG: la_d = GRN;
            AY: la_d = YLW;
            BG: lb_d = GRN;
            BY: lb_d = YLW;
            PW: walk_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= AG;
            cnt_q   <= '0;
            last_q  <= LAST_A;
            ped_q   <= 1'b0;
            la_q    <= GRN;
            lb_q    <= RED;
            walk_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            ped_q   <= ped_d;
            la_q    <= la_d;
            lb_q    <= lb_d;
            walk_q  <= walk_d;
        end
    end

    assign LA       = la_q;
    assign LB       = lb_q;
    assign walk     = walk_q;
    assign ped_pend = ped_q;
    assign phase    = state_q;

endmodule
`default_nettype wire

// File: tb/tb_traffic_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_traffic_sched
// Description : Directed self-checking bench for traffic_sched.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_traffic_sched;

    logic       clk;
    logic       reset;
    logic       tick;
    logic       a;
    logic       b;
    logic       ped_req;
    logic       emg;
    logic [1:0] LA;
    logic [1:0] LB;
    logic       walk;
    logic       ped_pend;
    logic [2:0] phase;

    int checks   = 0;
    int failures = 0;
    int tcnt     = 0;

    traffic_sched dut (
        .clk      (clk),
        .reset    (reset),
        .tick     (tick),
        .a        (a),
        .b        (b),
        .ped_req  (ped_req),
        .emg      (emg),
        .LA       (LA),
        .LB       (LB),
        .walk     (walk),
        .ped_pend (ped_pend),
        .phase    (phase)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One clock per call with tick on every fourth call overall.
    task automatic tick4(input int n);
        for (int i = 0; i < n; i++) begin
            tick = ((tcnt % 4) == 3);
            tcnt++;
            step(1);
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Expected lamps per phase: AG,AY,BG,BY,PW,ER.
    task automatic chk_state(input string tag, input int ph);
        logic [1:0] ela, elb;
        logic       ew;
        ela = 2'b10; elb = 2'b10; ew = 1'b0;
        case (ph)
            0: ela = 2'b00;
            1: ela = 2'b01;
            2: elb = 2'b00;
            3: elb = 2'b01;
            4: ew  = 1'b1;
            default: ;
        endcase
        chk({tag, "_phase"}, 32'(phase), 32'(ph));
        chk({tag, "_LA"},    32'(LA),    32'(ela));
        chk({tag, "_LB"},    32'(LB),    32'(elb));
        chk({tag, "_walk"},  32'(walk),  32'(ew));
    endtask

    initial begin
        // Reset has priority over emg, tick and ped_req.
        reset = 1'b0; emg = 1'b1; tick = 1'b1; a = 1'b1; b = 1'b1; ped_req = 1'b1;
        step(2);
        chk_state("reset", 0);
        chk("reset_pend", 32'(ped_pend), 0);
        reset = 1'b1; emg = 1'b0; ped_req = 1'b0;

        // Max green, both roads busy.
        step(19); chk_state("max_ag_hold", 0);
        step(1);  chk_state("max_ay", 1);
        step(2);  chk_state("max_ay_hold", 1);
        step(1);  chk_state("max_bg", 2);
        step(19); chk_state("max_bg_hold", 2);
        step(1);  chk_state("max_by", 3);
        step(3);  chk_state("max_back_ag", 0);

        // Min green, demand only on B.
        a = 1'b0;
        step(4); chk_state("min_ag_hold", 0);
        step(1); chk_state("min_ay", 1);
        step(2); chk_state("min_ay_hold", 1);
        step(1); chk_state("min_bg", 2);

        // No competing demand: BG holds (counter saturates).
        step(25); chk_state("nodemand_hold", 2);

        // Without tick no timed transition even with competing demand.
        a = 1'b1; b = 1'b0; tick = 1'b0;
        step(30); chk_state("notick_hold", 2);
        tick = 1'b1;
        step(1); chk_state("sat_by", 3);
        step(3); chk_state("sat_ag", 0);

        // Min green with tick every 4th clk: 20 clk then 12 clk.
        a = 1'b0; b = 1'b1;
        tick4(19); chk_state("slow_ag_hold", 0);
        tick4(1);  chk_state("slow_ay", 1);
        tick4(11); chk_state("slow_ay_hold", 1);
        tick4(1);  chk_state("slow_bg", 2);
        tick = 1'b1;

        // Back to AG for the pedestrian sequence.
        a = 1'b1; b = 1'b0;
        step(4); chk_state("to_ag_bg", 2);
        step(1); chk_state("to_ag_by", 3);
        step(3); chk_state("to_ag", 0);

        // Pedestrian request at tick 2 of AG.
        a = 1'b0; b = 1'b0;
        step(1);
        ped_req = 1'b1; step(1); ped_req = 1'b0;
        chk("ped_set", 32'(ped_pend), 1);
        step(2); chk_state("ped_ag_hold", 0);
        step(1); chk_state("ped_ay", 1);
        step(3); chk_state("ped_pw", 4);
        chk("ped_clr", 32'(ped_pend), 0);
        step(1);
        ped_req = 1'b1; step(1); ped_req = 1'b0;
        chk("ped_ignored_pw", 32'(ped_pend), 0);
        step(3); chk_state("ped_pw_hold", 4);
        step(1); chk_state("ped_bg", 2);

        // Emergency during AY.
        a = 1'b1;
        step(5); chk_state("emg_by", 3);
        step(3); chk_state("emg_ag", 0);
        a = 1'b0; b = 1'b1;
        step(5); chk_state("emg_ay", 1);
        step(1);
        emg = 1'b1;
        step(1);  chk_state("emg_er", 5);
        step(10); chk_state("emg_er_hold", 5);
        ped_req = 1'b1; step(1); ped_req = 1'b0;
        chk("emg_ped_set", 32'(ped_pend), 1);
        emg = 1'b0;
        step(1); chk_state("emg_exit_ag", 0);
        chk("emg_ped_kept", 32'(ped_pend), 1);
        step(4); chk_state("emg_ag_gmin_hold", 0);
        step(1); chk_state("emg_ag_exit", 1);
        step(3); chk_state("emg_pw", 4);
        step(6); chk_state("emg_pw_bg", 2);

        // Reset during BG with a pending pedestrian request.
        ped_req = 1'b1; step(1); ped_req = 1'b0;
        chk("rst_ped_set", 32'(ped_pend), 1);
        step(3); chk_state("rst_bg_hold", 2);
        reset = 1'b0;
        step(1); chk_state("rst_mid", 0);
        chk("rst_mid_pend", 32'(ped_pend), 0);
        reset = 1'b1;
        step(4); chk_state("rst_cnt_hold", 0);
        step(1); chk_state("rst_cnt_ay", 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
